// File: rtl/dmem_responder.sv
// Data-memory responder on the core bus: word RAM, a TX FIFO, a status word and a free-running
// cycle counter. All state commits on the falling clock edge, which is the core's commit edge.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  inout  logic [31:0] data,
  input  logic        mem,
  input  logic        mem_read,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [31:0] TXDATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'h1000_0008;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [31:0] ram [RAM_WORDS] = '{default: '0};
  logic [31:0] fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  rd_ptr, wr_ptr, ptr_diff;
  logic [PTR_W:0]    count;
  logic [31:0]       cycle_cnt;
  logic              err, ovf;
  logic              hit_ram, hit_tx, hit_status, hit_cycle, hit_unmapped;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en, push_req, push_ok, pop, full, empty;
  logic [2:0]        cnt_field;
  logic [31:0]       status_word, rd_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign hit_ram      = (addr[31:12] == '0) &&
                        ({1'b0, addr[31:2], 2'b00} < 33'(4 * RAM_WORDS));
  assign hit_tx       = (addr[31:2] == TXDATA_ADDR[31:2]);
  assign hit_status   = (addr[31:2] == STATUS_ADDR[31:2]);
  assign hit_cycle    = (addr[31:2] == CYCLE_ADDR[31:2]);
  assign hit_unmapped = !(hit_ram || hit_tx || hit_status || hit_cycle);
  assign ram_idx      = addr[RAM_AW+1:2];

  assign wr_en    = mem && !mem_read;
  assign push_req = wr_en && hit_tx;
  assign pop      = out_valid && out_ready;
  assign push_ok  = push_req && ((count != DEPTH_CNT) || pop);

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

  // Occupancy field is the pointer distance, so a full FIFO reads 0 here; the full bit
  // tells it apart from empty.
  assign ptr_diff    = wr_ptr - rd_ptr;
  assign cnt_field   = 3'(ptr_diff);
  assign status_word = {25'b0, ovf, err, cnt_field, empty, full};

  always_comb begin
    rd_data = '0;
    if (hit_ram)         rd_data = ram[ram_idx];
    else if (hit_status) rd_data = status_word;
    else if (hit_cycle)  rd_data = cycle_cnt;
  end

  assign data = (mem && mem_read) ? rd_data : {32{1'bz}};

  always_ff @(negedge clk) begin
    if (wr_en && hit_ram) ram[ram_idx] <= data;
    if (push_ok)          fifo_mem[wr_ptr] <= data;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      cycle_cnt <= (wr_en && hit_cycle) ? '0 : cycle_cnt + 32'd1;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!push_ok && pop) count <= count - (PTR_W+1)'(1);
      if (push_req && !push_ok) ovf <= 1'b1;
      if (mem && hit_unmapped)  err <= 1'b1;
    end
  end
endmodule
